// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int BCD_W      = 4;
  localparam int DIGITS_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

endpackage

// File: rtl/seg_slot_timer.sv
// Loadable down-counter shared by the BLANK and DRIVE intervals.
// done_o is high while the count sits at zero, i.e. in the last cycle of an
// interval that was loaded with (length - 1).
module seg_slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats decrement, saturate at zero.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller: multiplexes a double-buffered BCD frame onto one shared
// registered 7-segment decoder with a dark guard interval before each digit.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [BCD_W*DIGITS-1:0] frame_data,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic [BCD_W-1:0]        num,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_done
);

  localparam int FRAME_W  = BCD_W * DIGITS;
  localparam int SLOT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CNT_W    = $clog2(SLOT_MAX + 1);
  localparam int IDX_W    = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [FRAME_W-1:0] active_q, pending_q, frame_next;
  logic               pend_empty_q, pend_empty_d;
  logic [BCD_W-1:0]   num_q, num_d;
  logic [DIGITS-1:0]  an_q, an_d, digit_lit;
  logic               done_q, done_d;
  logic               timer_clear, timer_load, slot_done;
  logic [CNT_W-1:0]   timer_load_val;
  logic               load_accept, copy;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is lit if it or any more significant digit is nonzero; digit 0 always lit.
  function automatic logic [DIGITS-1:0] lit_mask(input logic [FRAME_W-1:0] frame);
    logic seen;
    lit_mask = '0;
    seen     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen        = seen | (frame[BCD_W*i +: BCD_W] != '0);
      lit_mask[i] = seen | (i == 0);
    end
  endfunction

  assign digit_lit = lit_mask(active_q);
`else
  assign digit_lit = '1;
`endif

  seg_slot_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (timer_clear),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .done_o     (slot_done)
  );

  assign load_accept = frame_valid && pend_empty_q;
  assign frame_next  = copy ? pending_q : active_q;

  // Scan FSM next state and registered outputs; enable low overrides everything.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    num_d          = num_q;
    an_d           = an_q;
    done_d         = 1'b0;
    timer_clear    = 1'b0;
    timer_load     = 1'b0;
    timer_load_val = BLANK_LOAD;
    copy           = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      index_d     = '0;
      an_d        = '0;
      timer_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = BLANK;
          index_d    = '0;
          an_d       = '0;
          timer_load = 1'b1;
          copy       = !pend_empty_q;
        end
        BLANK: begin
          if (slot_done) begin
            state_d          = DRIVE;
            an_d             = '0;
            an_d[index_q]    = digit_lit[index_q];
            timer_load       = 1'b1;
            timer_load_val   = DRIVE_LOAD;
          end
        end
        DRIVE: begin
          if (slot_done) begin
            state_d    = BLANK;
            an_d       = '0;
            timer_load = 1'b1;
            if (index_q == LAST_IDX) begin
              index_d = '0;
              done_d  = 1'b1;
              copy    = !pend_empty_q;
            end else begin
              index_d = index_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          an_d    = '0;
        end
      endcase
    end

    // The decoder input only changes on BLANK entry, so it settles while dark.
    if (state_d == BLANK && state_q != BLANK) begin
      num_d = frame_next[BCD_W*int'(index_d) +: BCD_W];
    end
  end

  // Pending buffer is freed by a copy and filled by an accepted load.
  always_comb begin
    pend_empty_d = pend_empty_q;
    if (load_accept)  pend_empty_d = 1'b0;
    else if (copy)    pend_empty_d = 1'b1;
  end

  // State, frame buffers and registered outputs.
  // NOTE: the frame buffers are reset too, since a reset must discard any displayed or pending frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_empty_q <= 1'b1;
      num_q        <= '0;
      an_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      pend_empty_q <= pend_empty_d;
      num_q        <= num_d;
      an_q         <= an_d;
      done_q       <= done_d;
      if (copy)        active_q  <= pending_q;
      if (load_accept) pending_q <= frame_data;
    end
  end

  assign frame_ready = pend_empty_q;
  assign num         = num_q;
  assign an          = an_q;
  assign frame_done  = done_q;

endmodule
